// File: rtl/amo_unit_pkg.sv
// +----------------------------------------------------------------------------+
// | amo_unit_pkg : atomic function codes, FSM state encodings, op decode helper |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package amo_unit_pkg;

    localparam logic [4:0] ATOMIC_ADD_OP  = 5'b00000;
    localparam logic [4:0] ATOMIC_SWAP_OP = 5'b00001;
    localparam logic [4:0] ATOMIC_LR_OP   = 5'b00010;
    localparam logic [4:0] ATOMIC_SC_OP   = 5'b00011;
    localparam logic [4:0] ATOMIC_XOR_OP  = 5'b00100;
    localparam logic [4:0] ATOMIC_OR_OP   = 5'b01000;
    localparam logic [4:0] ATOMIC_AND_OP  = 5'b01100;
    localparam logic [4:0] ATOMIC_MIN_OP  = 5'b10000;
    localparam logic [4:0] ATOMIC_MAX_OP  = 5'b10100;
    localparam logic [4:0] ATOMIC_MINU_OP = 5'b11000;
    localparam logic [4:0] ATOMIC_MAXU_OP = 5'b11100;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Read-modify-write ops only; LR/SC are decoded separately.
    function automatic logic is_rmw_op(input logic [4:0] op);
        case (op)
            ATOMIC_ADD_OP, ATOMIC_SWAP_OP, ATOMIC_XOR_OP, ATOMIC_OR_OP,
            ATOMIC_AND_OP, ATOMIC_MIN_OP, ATOMIC_MAX_OP, ATOMIC_MINU_OP,
            ATOMIC_MAXU_OP: is_rmw_op = 1'b1;
            default:        is_rmw_op = 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/amo_unit_atomic.sv
// +----------------------------------------------------------------------------+
// | amo_unit_atomic : combinational atomic combine of old value and rs2        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module amo_unit_atomic
    import amo_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] old_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] result_o
);

    logic w_slt;
    logic w_ult;

    // Strict less-than so that equal operands keep the old value.
    assign w_slt = $signed(wdata_i) < $signed(old_i);
    assign w_ult = wdata_i < old_i;

    always_comb begin
        result_o = old_i;
        case (op_i)
            ATOMIC_SWAP_OP: result_o = wdata_i;
            ATOMIC_SC_OP:   result_o = wdata_i;
            ATOMIC_ADD_OP:  result_o = old_i + wdata_i;
            ATOMIC_XOR_OP:  result_o = old_i ^ wdata_i;
            ATOMIC_OR_OP:   result_o = old_i | wdata_i;
            ATOMIC_AND_OP:  result_o = old_i & wdata_i;
            ATOMIC_MIN_OP:  result_o = w_slt ? wdata_i : old_i;
            ATOMIC_MAX_OP:  result_o = (!w_slt && (wdata_i != old_i)) ? wdata_i : old_i;
            ATOMIC_MINU_OP: result_o = w_ult ? wdata_i : old_i;
            ATOMIC_MAXU_OP: result_o = (!w_ult && (wdata_i != old_i)) ? wdata_i : old_i;
            default:        result_o = old_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/amo_unit.sv
// +----------------------------------------------------------------------------+
// | amo_unit : read-modify-write atomic memory op sequencer (IDLE/READ/WRITE/  |
// |            RESP). Optional LR/SC reservation enabled by AMO_LRSC_EN.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module amo_unit
    import amo_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [4:0]      req_op,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata
);

    logic [1:0]      state_q,  state_d;
    logic [4:0]      op_q,     op_d;
    logic [XLEN-1:2] addr_q,   addr_d;
    logic [XLEN-1:0] wdata_q,  wdata_d;
    logic [XLEN-1:0] old_q,    old_d;
    logic            err_q,    err_d;
    logic [XLEN-1:0] w_combined;
    logic            w_op_ok;

`ifdef AMO_LRSC_EN
    logic            resv_valid_q, resv_valid_d;
    logic [XLEN-1:2] resv_addr_q,  resv_addr_d;

    assign w_op_ok = is_rmw_op(req_op) || (req_op == ATOMIC_LR_OP) || (req_op == ATOMIC_SC_OP);
`else
    assign w_op_ok = is_rmw_op(req_op);
`endif

    amo_unit_atomic #(
        .XLEN     (XLEN)
    ) u_atomic (
        .op_i     (op_q),
        .old_i    (old_q),
        .wdata_i  (wdata_q),
        .result_o (w_combined)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        old_d   = old_q;
        err_d   = err_q;
`ifdef AMO_LRSC_EN
        resv_valid_d = resv_valid_q;
        resv_addr_d  = resv_addr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr[XLEN-1:2];
                    wdata_d = req_wdata;
                    old_d   = '0;
                    err_d   = 1'b0;
`ifdef AMO_LRSC_EN
                    if (req_op == ATOMIC_SC_OP) begin
                        resv_valid_d = 1'b0;
                    end
`endif
                    if ((req_addr[1:0] != 2'b00) || !w_op_ok) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
`ifdef AMO_LRSC_EN
                    // SC never reads: success writes straight away and reports 0.
                    else if (req_op == ATOMIC_SC_OP) begin
                        if (resv_valid_q && (resv_addr_q == req_addr[XLEN-1:2])) begin
                            state_d = ST_WRITE;
                        end else begin
                            old_d   = {{(XLEN-1){1'b0}}, 1'b1};
                            state_d = ST_RESP;
                        end
                    end
`endif
                    else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (mem_ack) begin
                    old_d   = mem_rdata;
                    state_d = ST_WRITE;
`ifdef AMO_LRSC_EN
                    if (op_q == ATOMIC_LR_OP) begin
                        resv_valid_d = 1'b1;
                        resv_addr_d  = addr_q;
                        state_d      = ST_RESP;
                    end
`endif
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    state_d = ST_RESP;
`ifdef AMO_LRSC_EN
                    if (resv_addr_q == addr_q) begin
                        resv_valid_d = 1'b0;
                    end
`endif
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            old_q   <= '0;
            err_q   <= 1'b0;
`ifdef AMO_LRSC_EN
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            old_q   <= old_d;
            err_q   <= err_d;
`ifdef AMO_LRSC_EN
            resv_valid_q <= resv_valid_d;
            resv_addr_q  <= resv_addr_d;
`endif
        end
    end

    // All outputs decode from registered state, so they hold while valid/req is high.
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = old_q;
    assign resp_err   = err_q;
    assign mem_req    = (state_q == ST_READ) || (state_q == ST_WRITE);
    assign mem_we     = (state_q == ST_WRITE);
    assign mem_addr   = {addr_q, 2'b00};
    assign mem_wdata  = (state_q == ST_WRITE) ? w_combined : '0;

endmodule

`default_nettype wire

// File: tb/tb_amo_unit.sv
// +----------------------------------------------------------------------------+
// | tb_amo_unit : randomized self-checking bench with a memory responder and a |
// |               behavioural AMO reference model. Rev 1.0                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_amo_unit;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SWAP = 5'b00001;
    localparam logic [4:0] OP_LR   = 5'b00010;
    localparam logic [4:0] OP_SC   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01100;
    localparam logic [4:0] OP_MIN  = 5'b10000;
    localparam logic [4:0] OP_MAX  = 5'b10100;
    localparam logic [4:0] OP_MINU = 5'b11000;
    localparam logic [4:0] OP_MAXU = 5'b11100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [logic [31:0]];
    int  ack_delay  = 0;
    bit  reads_only = 1'b0;
    bit  spur_ack   = 1'b0;
    int  wait_cnt   = 0;
    int  req_cycles = 0;
    int  n_writes   = 0;

    amo_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    // Reference: what the memory word should become after the atomic op.
    function automatic logic [31:0] ref_new(input logic [4:0] op, input logic [31:0] old, input logic [31:0] w);
        int signed so, sw;
        so = old;
        sw = w;
        case (op)
            OP_SWAP: return w;
            OP_ADD:  return old + w;
            OP_XOR:  return old ^ w;
            OP_OR:   return old | w;
            OP_AND:  return old & w;
            OP_MIN:  return (sw < so) ? w : old;
            OP_MAX:  return (sw > so) ? w : old;
            OP_MINU: return (w < old) ? w : old;
            OP_MAXU: return (w > old) ? w : old;
            default: return old;
        endcase
    endfunction

    // Memory responder: acks after ack_delay waiting cycles, commits writes on ack.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req === 1'b1) req_cycles++;
            if (spur_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = $urandom;
            end else if (rst_n && mem_req === 1'b1 && !(reads_only && mem_we)) begin
                if (wait_cnt >= ack_delay) begin
                    mem_ack  = 1'b1;
                    wait_cnt = 0;
                    if (mem_we) begin
                        mem[mem_addr] = mem_wdata;
                        n_writes++;
                    end else begin
                        mem_rdata = mem_rd(mem_addr);
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Issues one request; when finish is set also accepts the response.
    task automatic do_amo(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input bit finish, output logic [31:0] rd, output logic er, output int lat);
        bit got = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_idle: got %b want 1", req_ready);
        end
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (resp_valid === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL resp_timeout: op %b addr %h no resp_valid within 60 cycles", op, addr);
        end
        rd = resp_rdata;
        er = resp_err;
        if (finish) begin
            resp_ready = 1'b1;
            @(posedge clk);
            #1 resp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_err, mem_req, mem_we} !== 5'b10000 ||
            resp_rdata !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: rdy/vld/err/req/we=%b rdata=%h wdata=%h want 10000/0/0",
                     {req_ready, resp_valid, resp_err, mem_req, mem_we}, resp_rdata, mem_wdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] rd;
        logic er;
        int lat;
        logic [4:0]  ops [3] = '{OP_MIN, OP_MINU, OP_ADD};
        logic [31:0] exp [3] = '{32'hFFFF_FFFF, 32'h1, 32'h0};
        ack_delay = 0;
        mem[32'h100] = 32'h5;
        do_amo(OP_ADD, 32'h100, 32'h3, 1'b1, rd, er, lat);
        checks++;
        if (rd !== 32'h5 || er !== 1'b0 || mem_rd(32'h100) !== 32'h8 || lat != 4) begin
            errors++;
            $display("FAIL amoadd_basic: rdata=%h err=%b mem=%h lat=%0d want 5/0/8/4", rd, er, mem_rd(32'h100), lat);
        end
        for (int i = 0; i < 3; i++) begin
            mem[32'h104] = 32'hFFFF_FFFF;
            do_amo(ops[i], 32'h104, 32'h1, 1'b1, rd, er, lat);
            checks++;
            if (rd !== 32'hFFFF_FFFF || er !== 1'b0 || mem_rd(32'h104) !== exp[i]) begin
                errors++;
                $display("FAIL boundary_op%b: rdata=%h err=%b mem=%h want ffffffff/0/%h",
                         ops[i], rd, er, mem_rd(32'h104), exp[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0]  ops [9] = '{OP_ADD, OP_SWAP, OP_XOR, OP_OR, OP_AND, OP_MIN, OP_MAX, OP_MINU, OP_MAXU};
        logic [31:0] specials [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] rd, addr, wd, old, expn;
        logic [4:0]  op;
        logic er;
        int lat;
        for (int k = 0; k < 8; k++) mem[32'h200 + 4 * k] = $urandom;
        mem[32'h204] = 32'h8000_0000;
        for (int it = 0; it < 48; it++) begin
            op   = ops[$urandom_range(0, 8)];
            addr = 32'h200 + 4 * $urandom_range(0, 7);
            old  = mem_rd(addr);
            case ($urandom_range(0, 3))
                0: wd = specials[$urandom_range(0, 4)];
                1: wd = old;
                default: wd = $urandom;
            endcase
            expn = ref_new(op, old, wd);
            ack_delay = $urandom_range(0, 2);
            do_amo(op, addr, wd, 1'b1, rd, er, lat);
            checks++;
            if (rd !== old || er !== 1'b0 || mem_rd(addr) !== expn ||
                (ack_delay == 0 && lat != 4)) begin
                errors++;
                $display("FAIL random_amo op=%b old=%h w=%h: rdata=%h err=%b mem=%h lat=%0d want %h/0/%h",
                         op, old, wd, rd, er, mem_rd(addr), lat, old, expn);
            end
        end
        ack_delay = 0;
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic er;
        int lat, rc, nw;
        logic [4:0]  bad_ops  [6];
        logic [31:0] bad_addr [6];
        bad_ops  = '{OP_ADD, OP_SWAP, OP_MAXU, 5'b00101, 5'b11111, 5'b01001};
        bad_addr = '{32'h1002, 32'h1001, 32'h1003, 32'h1000, 32'h1000, 32'h1000};
        for (int i = 0; i < 6; i++) begin
            rc = req_cycles;
            nw = n_writes;
            do_amo(bad_ops[i], bad_addr[i], 32'h55, 1'b1, rd, er, lat);
            checks++;
            if (er !== 1'b1 || req_cycles != rc || n_writes != nw) begin
                errors++;
                $display("FAIL error_case op=%b addr=%h: err=%b mem_req_cycles=%0d want err 1, 0 cycles",
                         bad_ops[i], bad_addr[i], er, req_cycles - rc);
            end
        end
`ifndef AMO_LRSC_EN
        for (int i = 0; i < 2; i++) begin
            rc = req_cycles;
            do_amo((i == 0) ? OP_LR : OP_SC, 32'h100, 32'h9, 1'b1, rd, er, lat);
            checks++;
            if (er !== 1'b1 || req_cycles != rc) begin
                errors++;
                $display("FAIL lrsc_disabled_%0d: err=%b mem_req_cycles=%0d want 1/0", i, er, req_cycles - rc);
            end
        end
`endif
    endtask

`ifdef AMO_LRSC_EN
    task automatic test_lrsc();
        logic [31:0] rd;
        logic er;
        int lat, nw;
        mem[32'h100] = 32'hCAFE_0001;
        do_amo(OP_LR, 32'h100, 32'h0, 1'b1, rd, er, lat);
        checks++;
        if (rd !== 32'hCAFE_0001 || er !== 1'b0) begin
            errors++;
            $display("FAIL lr_value: rdata=%h err=%b want cafe0001/0", rd, er);
        end
        nw = n_writes;
        do_amo(OP_SC, 32'h100, 32'h1234_5678, 1'b1, rd, er, lat);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0 || mem_rd(32'h100) !== 32'h1234_5678 || n_writes != nw + 1) begin
            errors++;
            $display("FAIL sc_success: rdata=%h mem=%h writes=%0d want 0/12345678/1", rd, mem_rd(32'h100), n_writes - nw);
        end
        nw = n_writes;
        do_amo(OP_SC, 32'h100, 32'hDEAD_BEEF, 1'b1, rd, er, lat);
        checks++;
        if (rd !== 32'h1 || n_writes != nw || mem_rd(32'h100) !== 32'h1234_5678) begin
            errors++;
            $display("FAIL sc_again: rdata=%h writes=%0d want 1/0", rd, n_writes - nw);
        end
        do_amo(OP_LR, 32'h100, 32'h0, 1'b1, rd, er, lat);
        do_amo(OP_SWAP, 32'h100, 32'h7777, 1'b1, rd, er, lat);
        nw = n_writes;
        do_amo(OP_SC, 32'h100, 32'h9999, 1'b1, rd, er, lat);
        checks++;
        if (rd !== 32'h1 || n_writes != nw || mem_rd(32'h100) !== 32'h7777) begin
            errors++;
            $display("FAIL sc_after_swap: rdata=%h mem=%h want 1/7777", rd, mem_rd(32'h100));
        end
        do_amo(OP_LR, 32'h100, 32'h0, 1'b1, rd, er, lat);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        nw = n_writes;
        do_amo(OP_SC, 32'h100, 32'h4444, 1'b1, rd, er, lat);
        checks++;
        if (rd !== 32'h1 || n_writes != nw) begin
            errors++;
            $display("FAIL sc_after_reset: rdata=%h writes=%0d want 1/0", rd, n_writes - nw);
        end
    endtask
`endif

    task automatic test_reset_mid_write();
        bit in_write = 1'b0;
        logic [31:0] rd;
        logic er;
        int lat;
        mem[32'h300] = 32'h10;
        reads_only = 1'b1;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_ADD;
        req_addr  = 32'h300;
        req_wdata = 32'h1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 20 && !in_write; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1 && mem_we === 1'b1) in_write = 1'b1;
        end
        checks++;
        if (!in_write || mem_wdata !== 32'h11) begin
            errors++;
            $display("FAIL reach_write: reached=%0d wdata=%h want 1/00000011", in_write, mem_wdata);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || mem_req !== 1'b0 || resp_valid !== 1'b0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_write: ready=%b mem_req=%b resp_valid=%b wdata=%h want 1/0/0/0",
                     req_ready, mem_req, resp_valid, mem_wdata);
        end
        rst_n = 1'b1;
        reads_only = 1'b0;
        do_amo(OP_ADD, 32'h300, 32'h1, 1'b1, rd, er, lat);
        checks++;
        if (rd !== 32'h10 || mem_rd(32'h300) !== 32'h11) begin
            errors++;
            $display("FAIL after_abandon: rdata=%h mem=%h want 10/11", rd, mem_rd(32'h300));
        end
    endtask

    task automatic test_resp_hold();
        logic [31:0] rd;
        logic er;
        int lat;
        mem[32'h400] = 32'hA5A5_A5A5;
        do_amo(OP_SWAP, 32'h400, 32'h1234, 1'b0, rd, er, lat);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) spur_ack = 1'b1;
            @(posedge clk);
            #1 spur_ack = 1'b0;
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'hA5A5_A5A5 || resp_err !== 1'b0 ||
                req_ready !== 1'b0 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL resp_hold_c%0d: valid=%b rdata=%h err=%b ready=%b mem_req=%b want 1/a5a5a5a5/0/0/0",
                         c, resp_valid, resp_rdata, resp_err, req_ready, mem_req);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_rd(32'h400) !== 32'h1234) begin
            errors++;
            $display("FAIL resp_release: ready=%b valid=%b mem=%h want 1/0/1234", req_ready, resp_valid, mem_rd(32'h400));
        end
    endtask

    task automatic test_idle_ack();
        int rc = req_cycles;
        int nw = n_writes;
        @(negedge clk);
        #1 spur_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 spur_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || mem_req !== 1'b0 || resp_valid !== 1'b0 || n_writes != nw || req_cycles != rc) begin
            errors++;
            $display("FAIL idle_ack_ignored: ready=%b mem_req=%b resp_valid=%b want 1/0/0", req_ready, mem_req, resp_valid);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 5'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_errors();
`ifdef AMO_LRSC_EN
        test_lrsc();
`endif
        test_reset_mid_write();
        test_resp_hold();
        test_idle_ack();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/amo_unit.md
AMO_UNIT -- requirements
Module: amo_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data and address width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous reset, active low.
REQ-004 SHALL have port req_valid  input  1  core presents an atomic request.
REQ-005 SHALL have port req_ready  output  1  unit accepts the request this cycle (high only in IDLE).
REQ-006 SHALL have port req_op  input  5  atomic function code (ATOMIC_*_OP encodings).
REQ-007 SHALL have port req_addr  input  XLEN  target byte address.
REQ-008 SHALL have port req_wdata  input  XLEN  rs2 operand.
REQ-009 SHALL have port resp_valid  output  1  response available; held until resp_ready.
REQ-010 SHALL have port resp_ready  input  1  core accepts the response.
REQ-011 SHALL have port resp_rdata  output  XLEN  old memory value, or SC status word.
REQ-012 SHALL have port resp_err  output  1  misaligned address or unsupported op.
REQ-013 SHALL have port mem_req  output  1  memory access request; held until mem_ack.
REQ-014 SHALL have port mem_we  output  1  1 = write, 0 = read.
REQ-015 SHALL have port mem_addr  output  XLEN  word address (req_addr, low two bits zero).
REQ-016 SHALL have port mem_wdata  output  XLEN  write data.
REQ-017 SHALL have port mem_ack  input  1  single-cycle completion pulse.
REQ-018 SHALL have port mem_rdata  input  XLEN  read data, valid in the mem_ack cycle.

Function
REQ-019 SHALL implement FSM states IDLE, READ, WRITE, RESP.
REQ-020 IDLE: on req_valid&&req_ready, SHALL latch op/addr/wdata.
REQ-021 From IDLE, the FSM SHALL go to RESP with resp_err=1 and no memory access if req_addr[1:0]!=0 or req_op is not a supported code; otherwise it SHALL go to READ.
REQ-022 READ: SHALL drive mem_req=1 and mem_we=0; on mem_ack SHALL latch mem_rdata as old.
REQ-023 After READ, the FSM SHALL go to WRITE, except LR, which SHALL go to RESP.
REQ-024 WRITE: SHALL drive mem_req=1, mem_we=1, mem_wdata=combine(old, wdata, op); on mem_ack SHALL go to RESP.
REQ-025 combine SHALL be: SWAP->wdata; ADD->old+wdata, mod 2^XLEN; XOR/AND/OR bitwise; MIN/MAX signed compare; MINU/MAXU unsigned compare; ties SHALL return old.
REQ-026 RESP: resp_valid=1, resp_rdata=old; on resp_ready the FSM SHALL return to IDLE.
REQ-027 mem_req SHALL NOT be asserted in IDLE or RESP.
REQ-028 Outputs (mem_addr, mem_wdata, resp_rdata, resp_err) SHALL be stable while their valid/req is high.
REQ-029 A non-error AMO SHALL complete with minimum latency 4 cycles, accept to resp_valid, with mem_ack asserted in the first cycle of each memory access.
REQ-030 An mem_ack arriving in IDLE or RESP SHALL be ignored.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force IDLE and clear resp_valid, resp_err, mem_req, mem_we, resp_rdata, mem_wdata, and the reservation, including mid-operation; a write in progress SHALL be abandoned.

Configuration
REQ-032 With AMO_LRSC_EN defined, LR (00010) SHALL read, return the value, and set reservation {valid, addr}.
REQ-033 With AMO_LRSC_EN defined, SC (00011) SHALL perform WRITE of wdata then respond 0 when the reservation is valid with an equal address; otherwise it SHALL skip memory and respond 1.
REQ-034 With AMO_LRSC_EN defined, every SC SHALL clear the reservation.
REQ-035 With AMO_LRSC_EN defined, any AMO write to the reserved address SHALL clear the reservation.
REQ-036 Without AMO_LRSC_EN, LR/SC SHALL be unsupported (resp_err=1) and no reservation register SHALL exist.

Structure
REQ-037 ATOMIC_*_OP codes (ADD 00000, SWAP 00001, LR 00010, SC 00011, XOR 00100, OR 01000, AND 01100, MIN 10000, MAX 10100, MINU 11000, MAXU 11100) and FSM state encodings SHALL live in the shared defines package.
REQ-038 combine SHALL be the team's existing combinational atomic unit instantiated as sub-module atomic; no other sub-modules.

Verification
REQ-039 Test 1: old=0x00000005, AMOADD wdata=0x3 -> write 0x8, resp_rdata=0x5.
REQ-040 Test 2: old=0xFFFFFFFF, wdata=0x1: AMOMIN -> write 0xFFFFFFFF; AMOMINU -> write 0x1; AMOADD -> write 0x0 (wrap).
REQ-041 Test 3: req_addr=0x1002 -> resp_err=1, mem_req never asserted.
REQ-042 Test 4 (AMO_LRSC_EN): LR 0x100, SC 0x100 -> write, resp 0; SC again -> no write, resp 1; LR 0x100, AMOSWAP 0x100, SC -> resp 1.
REQ-043 Test 5: rst_n low during WRITE with mem_ack delayed -> next cycle IDLE, mem_req=0, req_ready=1.
REQ-044 Test 6: resp_ready held low 5 cycles -> resp_valid and resp_rdata stable, req_ready=0 throughout.
